// File: rtl/mfp_reset_sequencer_pkg.sv
// Shared types and helpers for the board reset sequencer.
// Holds the sequencer state encoding and the counter-width rule used by every counter.
package mfp_reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_STRETCH = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } seq_state_e;

    localparam int DEF_N_SRC     = 2;
    localparam int DEF_N_DOMAINS = 3;

    // Bits needed to hold 0..max_value; never narrower than one bit.
    function automatic int cnt_width(input int max_value);
        if (max_value < 1) begin
            return 1;
        end else begin
            return $clog2(max_value + 1);
        end
    endfunction

endpackage

// File: rtl/mfp_reset_sequencer_if.sv
// Pin-side bundle of the reset sequencer: request inputs, cause control and sequenced resets.
// The board side uses the master modport; the sequencer uses the slave modport.
interface mfp_reset_sequencer_if #(
    parameter int N_SRC     = 2,
    parameter int N_DOMAINS = 3
);
    logic [N_SRC-1:0]     req_n;
    logic                 cause_clr;
    logic [N_DOMAINS-1:0] dom_reset;
    logic                 cold_reset;
    logic [N_SRC:0]       cause;
    logic                 busy;

    modport master (
        output req_n,
        output cause_clr,
        input  dom_reset,
        input  cold_reset,
        input  cause,
        input  busy
    );

    modport slave (
        input  req_n,
        input  cause_clr,
        output dom_reset,
        output cold_reset,
        output cause,
        output busy
    );
endinterface

// File: rtl/mfp_reset_sequencer_src_filter.sv
// One reset-request input: synchroniser on the raw active-low pin followed by a debounce filter.
// The filtered level flips only after the synchronised value has disagreed with it for DEBOUNCE_CYCLES cycles.
module mfp_reset_src_filter
    import mfp_reset_sequencer_pkg::*;
#(
    parameter int N_SYNC          = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req_n,
    output logic level
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

    // The chain carries the raw pin, so the all-ones reset value means "not requesting".
    logic [N_SYNC-1:0] sync_r;
    logic [CNT_W-1:0]  stable_cnt_r;
    logic [CNT_W-1:0]  stable_cnt_nxt_s;
    logic              level_r;
    logic              level_nxt_s;
    logic              sampled_s;

    assign sampled_s = ~sync_r[N_SYNC-1];
    assign level     = level_r;

    // Debounce: count consecutive disagreeing cycles, restart on any bounce.
    always_comb begin
        stable_cnt_nxt_s = stable_cnt_r;
        level_nxt_s      = level_r;
        if (sampled_s != level_r) begin
            if (stable_cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_nxt_s      = sampled_s;
                stable_cnt_nxt_s = CNT_W'(0);
            end else begin
                level_nxt_s      = level_r;
                stable_cnt_nxt_s = stable_cnt_r + CNT_W'(1);
            end
        end else begin
            level_nxt_s      = level_r;
            stable_cnt_nxt_s = CNT_W'(0);
        end
    end

    // Synchroniser, stability counter and filtered level registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r       <= {N_SYNC{1'b1}};
            stable_cnt_r <= CNT_W'(0);
            level_r      <= 1'b0;
        end else begin
            sync_r       <= {sync_r[N_SYNC-2:0], req_n};
            stable_cnt_r <= stable_cnt_nxt_s;
            level_r      <= level_nxt_s;
        end
    end

endmodule

// File: rtl/mfp_reset_sequencer.sv
// Board reset controller: merges filtered reset requests, stretches the reset, then releases
// the domain resets in staggered order while tracking cold reset and a sticky reset cause.
module mfp_reset_sequencer
    import mfp_reset_sequencer_pkg::*;
#(
    parameter int               N_SRC           = DEF_N_SRC,
    parameter int               N_DOMAINS       = DEF_N_DOMAINS,
    parameter int               N_SYNC          = 2,
    parameter int               DEBOUNCE_CYCLES = 4,
    parameter int               STRETCH_CYCLES  = 8,
    parameter int               STAGGER_CYCLES  = 2,
    parameter logic [N_SRC-1:0] COLD_MASK       = {N_SRC{1'b0}}
) (
    input  logic                    clk,
    input  logic                    rst,
    mfp_reset_sequencer_if.slave    bus
);

    localparam int STR_W = cnt_width(STRETCH_CYCLES);
    localparam int STG_W = cnt_width(STAGGER_CYCLES);
    localparam int IDX_W = cnt_width(N_DOMAINS);
    localparam logic [N_DOMAINS-1:0] ALL_ON  = {N_DOMAINS{1'b1}};
    localparam logic [N_DOMAINS-1:0] ALL_OFF = {N_DOMAINS{1'b0}};

    logic [N_SRC-1:0]     level_s;
    logic [N_SRC-1:0]     level_prev_r;
    logic [N_SRC-1:0]     rise_s;
    logic                 req_any_s;
    logic                 cold_trig_s;
    logic                 release0_s;

    seq_state_e           state_r;
    seq_state_e           state_nxt_s;
    logic [STR_W-1:0]     stretch_cnt_r;
    logic [STR_W-1:0]     stretch_cnt_nxt_s;
    logic [STG_W-1:0]     stagger_cnt_r;
    logic [STG_W-1:0]     stagger_cnt_nxt_s;
    logic [IDX_W-1:0]     rel_idx_r;
    logic [IDX_W-1:0]     rel_idx_nxt_s;
    logic [N_DOMAINS-1:0] dom_reset_r;
    logic [N_DOMAINS-1:0] dom_reset_nxt_s;
    logic                 cold_pending_r;
    logic                 cold_pending_nxt_s;
    logic [N_SRC:0]       cause_r;
    logic [N_SRC:0]       cause_nxt_s;
    logic                 busy_r;
    logic                 busy_nxt_s;

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        mfp_reset_src_filter #(
            .N_SYNC          (N_SYNC),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_filter (
            .clk   (clk),
            .rst   (rst),
            .req_n (bus.req_n[g]),
            .level (level_s[g])
        );
    end

    assign rise_s      = level_s & ~level_prev_r;
    assign req_any_s   = |level_s;
    assign cold_trig_s = |(rise_s & COLD_MASK);

    assign bus.dom_reset  = dom_reset_r;
    assign bus.cold_reset = cold_pending_r;
    assign bus.cause      = cause_r;
    assign bus.busy       = busy_r;

    // Sequencer next state; an active request from any state restarts from ASSERT with no credit.
    always_comb begin
        state_nxt_s       = state_r;
        stretch_cnt_nxt_s = stretch_cnt_r;
        stagger_cnt_nxt_s = stagger_cnt_r;
        rel_idx_nxt_s     = rel_idx_r;
        dom_reset_nxt_s   = dom_reset_r;
        release0_s        = 1'b0;
        if (req_any_s) begin
            state_nxt_s       = ST_ASSERT;
            dom_reset_nxt_s   = ALL_ON;
            stretch_cnt_nxt_s = STR_W'(0);
            stagger_cnt_nxt_s = STG_W'(0);
            rel_idx_nxt_s     = IDX_W'(0);
        end else begin
            case (state_r)
                ST_ASSERT: begin
                    state_nxt_s       = ST_STRETCH;
                    dom_reset_nxt_s   = ALL_ON;
                    stretch_cnt_nxt_s = STR_W'(0);
                    stagger_cnt_nxt_s = STG_W'(0);
                    rel_idx_nxt_s     = IDX_W'(0);
                end
                ST_STRETCH: begin
                    if (stretch_cnt_r == STR_W'(STRETCH_CYCLES - 1)) begin
                        dom_reset_nxt_s[0] = 1'b0;
                        release0_s         = 1'b1;
                        stretch_cnt_nxt_s  = STR_W'(0);
                        stagger_cnt_nxt_s  = STG_W'(0);
                        rel_idx_nxt_s      = IDX_W'(1);
                        if (N_DOMAINS == 1) begin
                            state_nxt_s = ST_RUN;
                        end else begin
                            state_nxt_s = ST_RELEASE;
                        end
                    end else begin
                        stretch_cnt_nxt_s = stretch_cnt_r + STR_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (stagger_cnt_r == STG_W'(STAGGER_CYCLES - 1)) begin
                        for (int k = 0; k < N_DOMAINS; k++) begin
                            if (rel_idx_r == IDX_W'(k)) begin
                                dom_reset_nxt_s[k] = 1'b0;
                            end else begin
                                dom_reset_nxt_s[k] = dom_reset_r[k];
                            end
                        end
                        stagger_cnt_nxt_s = STG_W'(0);
                        rel_idx_nxt_s     = rel_idx_r + IDX_W'(1);
                        if (rel_idx_r == IDX_W'(N_DOMAINS - 1)) begin
                            state_nxt_s = ST_RUN;
                        end else begin
                            state_nxt_s = ST_RELEASE;
                        end
                    end else begin
                        stagger_cnt_nxt_s = stagger_cnt_r + STG_W'(1);
                    end
                end
                ST_RUN: begin
                    state_nxt_s     = ST_RUN;
                    dom_reset_nxt_s = ALL_OFF;
                end
                default: begin
                    state_nxt_s       = ST_ASSERT;
                    dom_reset_nxt_s   = ALL_ON;
                    stretch_cnt_nxt_s = STR_W'(0);
                    stagger_cnt_nxt_s = STG_W'(0);
                    rel_idx_nxt_s     = IDX_W'(0);
                end
            endcase
        end
    end

    // Cold pending, sticky cause and busy next values.
    always_comb begin
        busy_nxt_s = (state_nxt_s != ST_RUN);
        if (cold_trig_s) begin
            cold_pending_nxt_s = 1'b1;
        end else if (release0_s) begin
            cold_pending_nxt_s = 1'b0;
        end else begin
            cold_pending_nxt_s = cold_pending_r;
        end
        // A trigger landing on the clear cycle survives the clear.
        if (bus.cause_clr) begin
            cause_nxt_s = {1'b0, rise_s};
        end else begin
            cause_nxt_s = cause_r | {1'b0, rise_s};
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_ASSERT;
            stretch_cnt_r  <= STR_W'(0);
            stagger_cnt_r  <= STG_W'(0);
            rel_idx_r      <= IDX_W'(0);
            dom_reset_r    <= ALL_ON;
            cold_pending_r <= 1'b1;
            cause_r        <= {1'b1, {N_SRC{1'b0}}};
            busy_r         <= 1'b1;
            level_prev_r   <= {N_SRC{1'b0}};
        end else begin
            state_r        <= state_nxt_s;
            stretch_cnt_r  <= stretch_cnt_nxt_s;
            stagger_cnt_r  <= stagger_cnt_nxt_s;
            rel_idx_r      <= rel_idx_nxt_s;
            dom_reset_r    <= dom_reset_nxt_s;
            cold_pending_r <= cold_pending_nxt_s;
            cause_r        <= cause_nxt_s;
            busy_r         <= busy_nxt_s;
            level_prev_r   <= level_s;
        end
    end

endmodule

// File: tb/tb_mfp_reset_sequencer.sv
// Self-checking bench for mfp_reset_sequencer: directed scenarios with literal expectations,
// then random request traffic, all compared each cycle against a timestamp-based reference model.
module tb_mfp_reset_sequencer;

    localparam int N_SRC     = 2;
    localparam int N_DOMAINS = 3;
    localparam int N_SYNC    = 2;
    localparam int DEB       = 4;
    localparam int STRETCH   = 8;
    localparam int STAGGER   = 2;
    localparam logic [N_SRC-1:0] COLD_MASK = 2'b10;
    localparam int MAXC      = 8192;

    logic clk;
    logic rst;

    mfp_reset_sequencer_if #(.N_SRC(N_SRC), .N_DOMAINS(N_DOMAINS)) dut_if ();

    mfp_reset_sequencer #(
        .N_SRC           (N_SRC),
        .N_DOMAINS       (N_DOMAINS),
        .N_SYNC          (N_SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .STRETCH_CYCLES  (STRETCH),
        .STAGGER_CYCLES  (STAGGER),
        .COLD_MASK       (COLD_MASK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: request history per source plus the edge of the last reset activity.
    logic             req_hist [N_SRC][MAXC];
    logic [N_SRC-1:0] lvl_m;
    logic [N_SRC-1:0] prev_m;
    int               last_rst = 0;
    int               last_act = 0;
    logic             cold_m;
    logic [N_SRC:0]   cause_m;
    logic [N_DOMAINS-1:0] dom_m;
    logic             busy_m;
    bit               model_valid = 1'b0;

    // Request value (1 = requesting) seen by the debounce logic just before edge j.
    function automatic logic synced_req(input int i, input int j);
        if ((j - N_SYNC > last_rst) && (j - N_SYNC >= 1)) begin
            return ~req_hist[i][j - N_SYNC];
        end else begin
            return 1'b0;
        end
    endfunction

    initial begin
        logic [N_SRC-1:0] rise;
        logic             any;
        logic             flip;
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < N_SRC; i++) req_hist[i][cyc] = dut_if.req_n[i];
            if (rst) begin
                last_rst    = cyc;
                last_act    = cyc;
                lvl_m       = '0;
                prev_m      = '0;
                cold_m      = 1'b1;
                cause_m     = {1'b1, {N_SRC{1'b0}}};
                model_valid = 1'b1;
            end else begin
                rise   = lvl_m & ~prev_m;
                any    = |lvl_m;
                prev_m = lvl_m;
                for (int i = 0; i < N_SRC; i++) begin
                    flip = (cyc - DEB + 1 > last_rst);
                    for (int j = cyc - DEB + 1; j <= cyc; j++) begin
                        if (synced_req(i, j) == lvl_m[i]) flip = 1'b0;
                    end
                    if (flip) lvl_m[i] = ~lvl_m[i];
                end
                if (any) last_act = cyc;
                if (|(rise & COLD_MASK)) cold_m = 1'b1;
                if (dut_if.cause_clr) cause_m = {1'b0, rise};
                else                  cause_m = cause_m | {1'b0, rise};
                if (cyc == last_act + 1 + STRETCH) cold_m = 1'b0;
            end
            for (int k = 0; k < N_DOMAINS; k++) begin
                dom_m[k] = (cyc < last_act + 1 + STRETCH + k * STAGGER);
            end
            busy_m = (cyc < last_act + 1 + STRETCH + (N_DOMAINS - 1) * STAGGER);
        end
    end

    // Every-cycle comparison against the model, on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (model_valid) begin
                check("model_dom_reset", 32'(dut_if.dom_reset), 32'(dom_m));
                check("model_cold_reset", 32'(dut_if.cold_reset), 32'(cold_m));
                check("model_busy", 32'(dut_if.busy), 32'(busy_m));
                check("model_cause", 32'(dut_if.cause), 32'(cause_m));
            end
        end
    end

    initial begin
        int n;
        rst              = 1'b1;
        dut_if.req_n     = 2'b11;
        dut_if.cause_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Power-on sequence
        step(8);
        check("por_dom_e8", 32'(dut_if.dom_reset), 32'h7);
        check("por_cold_e8", 32'(dut_if.cold_reset), 32'h1);
        step(1);
        check("por_dom_e9", 32'(dut_if.dom_reset), 32'h6);
        check("por_cold_e9", 32'(dut_if.cold_reset), 32'h0);
        step(2);
        check("por_dom_e11", 32'(dut_if.dom_reset), 32'h4);
        check("por_busy_e11", 32'(dut_if.busy), 32'h1);
        step(2);
        check("por_dom_e13", 32'(dut_if.dom_reset), 32'h0);
        check("por_busy_e13", 32'(dut_if.busy), 32'h0);
        check("por_cause", 32'(dut_if.cause), 32'h4);

        // Glitch shorter than the debounce window
        step(2);
        dut_if.req_n = 2'b10;
        step(3);
        dut_if.req_n = 2'b11;
        step(12);
        check("glitch_dom", 32'(dut_if.dom_reset), 32'h0);
        check("glitch_busy", 32'(dut_if.busy), 32'h0);
        check("glitch_cause", 32'(dut_if.cause), 32'h4);

        // Warm reset from source 0
        dut_if.cause_clr = 1'b1;
        step(1);
        dut_if.cause_clr = 1'b0;
        dut_if.req_n     = 2'b10;
        step(6);
        check("warm_dom_e6", 32'(dut_if.dom_reset), 32'h0);
        step(1);
        check("warm_dom_e7", 32'(dut_if.dom_reset), 32'h7);
        check("warm_cold_e7", 32'(dut_if.cold_reset), 32'h0);
        check("warm_cause", 32'(dut_if.cause), 32'h1);
        step(13);
        dut_if.req_n = 2'b11;
        step(14);
        check("warm_rel_dom_e14", 32'(dut_if.dom_reset), 32'h7);
        step(1);
        check("warm_rel_dom_e15", 32'(dut_if.dom_reset), 32'h6);
        step(4);
        check("warm_rel_dom_e19", 32'(dut_if.dom_reset), 32'h0);
        check("warm_rel_busy_e19", 32'(dut_if.busy), 32'h0);
        step(3);

        // Cold reset from source 1, then re-trigger from source 0 mid-release
        dut_if.req_n = 2'b01;
        step(7);
        check("cold_dom_e7", 32'(dut_if.dom_reset), 32'h7);
        check("cold_cold_e7", 32'(dut_if.cold_reset), 32'h1);
        check("cold_cause", 32'(dut_if.cause), 32'h3);
        step(13);
        dut_if.req_n = 2'b11;
        step(10);
        dut_if.req_n = 2'b10;
        step(4);
        check("cold_rel_e14", 32'(dut_if.cold_reset), 32'h1);
        step(1);
        check("cold_rel_dom_e15", 32'(dut_if.dom_reset), 32'h6);
        check("cold_rel_cold_e15", 32'(dut_if.cold_reset), 32'h0);
        step(2);
        check("retrig_dom_e17", 32'(dut_if.dom_reset), 32'h7);
        check("retrig_busy_e17", 32'(dut_if.busy), 32'h1);
        step(3);
        dut_if.req_n = 2'b11;
        step(14);
        check("retrig_stretch_e14", 32'(dut_if.dom_reset), 32'h7);
        step(1);
        check("retrig_stretch_e15", 32'(dut_if.dom_reset), 32'h6);
        step(5);

        // cause_clr on the same edge as a new source-0 trigger
        dut_if.req_n = 2'b10;
        step(6);
        dut_if.cause_clr = 1'b1;
        step(1);
        dut_if.cause_clr = 1'b0;
        check("race_cause", 32'(dut_if.cause), 32'h1);
        step(13);
        dut_if.req_n = 2'b11;
        step(16);
        check("race_dom_e16", 32'(dut_if.dom_reset), 32'h6);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rst_mid_dom", 32'(dut_if.dom_reset), 32'h7);
        check("rst_mid_cold", 32'(dut_if.cold_reset), 32'h1);
        check("rst_mid_busy", 32'(dut_if.busy), 32'h1);
        check("rst_mid_cause", 32'(dut_if.cause), 32'h4);
        step(20);

        // Random request traffic with occasional clears and resets
        for (int s = 0; s < 150; s++) begin
            dut_if.req_n     = 2'($urandom_range(0, 3));
            dut_if.cause_clr = ($urandom_range(0, 9) == 0);
            rst              = ($urandom_range(0, 39) == 0);
            step(1);
            dut_if.cause_clr = 1'b0;
            rst              = 1'b0;
            n = $urandom_range(1, 25);
            step(n);
        end
        dut_if.req_n = 2'b11;
        step(40);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
